// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: reusable pipeline stage register with valid/ready handshake,
// synchronous flush and a saturating downstream stall-cycle counter.
// Build option: define PIPE_SKID_EN for a 2-entry skid buffer with a registered
// in_ready. Without it the stage is a single register with combinational
// in_ready.
module pipe_stage_hs #(
  parameter int unsigned WIDTH = 224,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned OccW = 2;

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} stateT;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1} stateT;
`endif

  stateT            stateQ, stateD;
  logic [WIDTH-1:0] mainQ, mainD;
  logic             validQ, validD;
  logic [CNT_W-1:0] stallQ;
`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] skidQ, skidD;
  logic             readyQ, readyD;
  logic [OccW-1:0]  occQ, occD;
`endif

  // Next-state, next-payload and registered-output decode; flush overrides all.
  always_comb begin
    stateD = stateQ;
    mainD  = mainQ;
`ifdef PIPE_SKID_EN
    skidD  = skidQ;
`endif
    case (stateQ)
      EMPTY: begin
        if (in_valid) begin
          stateD = FULL;
          mainD  = in_data;
        end
      end
`ifdef PIPE_SKID_EN
      FULL: begin
        if (in_valid && out_ready) begin
          mainD = in_data;
        end else if (in_valid) begin
          stateD = SKID;
          skidD  = in_data;
        end else if (out_ready) begin
          stateD = EMPTY;
        end
      end
      SKID: begin
        // Input is refused here, so the skid entry simply moves up.
        if (out_ready) begin
          stateD = FULL;
          mainD  = skidQ;
        end
      end
`else
      FULL: begin
        // Without skid storage an input is only taken when the head leaves.
        if (out_ready) begin
          if (in_valid) begin
            mainD = in_data;
          end else begin
            stateD = EMPTY;
          end
        end
      end
`endif
      default: stateD = EMPTY;
    endcase

    if (flush) begin
      stateD = EMPTY;
      mainD  = '0;
`ifdef PIPE_SKID_EN
      skidD  = '0;
`endif
    end

    validD = (stateD != EMPTY);
`ifdef PIPE_SKID_EN
    readyD = (stateD != SKID);
    occD   = (stateD == SKID) ? OccW'(2) : ((stateD == FULL) ? OccW'(1) : OccW'(0));
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= EMPTY;
    end else begin
      stateQ <= stateD;
    end
  end

  // Payload storage and registered handshake/occupancy outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mainQ  <= '0;
      validQ <= 1'b0;
`ifdef PIPE_SKID_EN
      skidQ  <= '0;
      readyQ <= 1'b1;
      occQ   <= '0;
`endif
    end else begin
      mainQ  <= mainD;
      validQ <= validD;
`ifdef PIPE_SKID_EN
      skidQ  <= skidD;
      readyQ <= readyD;
      occQ   <= occD;
`endif
    end
  end

  // Saturating count of cycles where a held payload waits on downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallQ <= '0;
    end else if (validQ && !out_ready && (stallQ != {CNT_W{1'b1}})) begin
      stallQ <= stallQ + CNT_W'(1);
    end
  end

  assign out_valid = validQ;
  assign out_data  = mainQ;
  assign stall_cnt = stallQ;

`ifdef PIPE_SKID_EN
  assign in_ready  = readyQ;
  assign occupancy = occQ;
`else
  assign in_ready  = ~validQ | out_ready;
  assign occupancy = {1'b0, validQ};
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: queue-based reference model of the stage with a
// scoreboard of expected payloads, plus directed checks of reset, streaming,
// back-pressure, flush, counter saturation and asynchronous reset.
module tb_pipe_stage_hs;

  localparam int unsigned W = 8;
  localparam int unsigned CW = 4;
`ifdef PIPE_SKID_EN
  localparam bit SkidEn = 1'b1;
`else
  localparam bit SkidEn = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  pipe_stage_hs #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   failures = 0;
  logic [W-1:0]  srcQ[$];     // payloads waiting to be offered upstream
  logic [W-1:0]  mq[$];       // scoreboard: payloads the stage should hold
  logic [W-1:0]  recvQ[$];    // payloads observed leaving the DUT
  int unsigned   mStall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic cycle(input logic outR, input logic fl, input logic inEn);
    logic         mReady;
    logic         accept;
    logic         deliver;
    logic [W-1:0] captured;
    in_valid  = inEn && (srcQ.size() > 0);
    in_data   = in_valid ? srcQ[0] : W'($urandom);
    out_ready = outR;
    flush     = fl;
    #1;
    mReady = SkidEn ? (mq.size() < 2) : ((mq.size() == 0) || outR);
    chk("in_ready", 32'(in_ready), 32'(mReady));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("stall_cnt", 32'(stall_cnt), 32'(mStall));
    if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    if (out_valid && outR) recvQ.push_back(out_data);
    accept   = in_valid && mReady;
    deliver  = (mq.size() > 0) && outR;
    captured = in_data;
    if ((mq.size() > 0) && !outR && (mStall != 15)) mStall++;
    @(posedge clk);
    if (deliver) void'(mq.pop_front());
    if (accept) begin
      void'(srcQ.pop_front());
      if (!fl) mq.push_back(captured);
    end
    if (fl) mq.delete();
    @(negedge clk);
  endtask

  initial begin
    clk       = 1'b0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom);
      in_data   = W'($urandom);
      out_ready = 1'($urandom);
      flush     = 1'($urandom);
      @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    end
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Streaming 0x01..0x10 with out_ready high.
    for (int i = 1; i <= 16; i++) srcQ.push_back(W'(i));
    recvQ.delete();
    for (int i = 0; i < 18; i++) cycle(1'b1, 1'b0, 1'b1);
    chk("stream_count", 32'(recvQ.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < recvQ.size()) chk("stream_order", 32'(recvQ[i]), 32'(i + 1));
    chk("stream_stall", 32'(stall_cnt), 32'd0);

    // Back-pressure: A1 shown, then out_ready low for 3 cycles.
    srcQ = '{8'hA1, 8'hA2, 8'hA3};
    recvQ.delete();
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("bp_occupancy", 32'(occupancy), SkidEn ? 32'd2 : 32'd1);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_stall_cnt", 32'(stall_cnt), 32'd3);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1);
    chk("bp_count", 32'(recvQ.size()), 32'd3);
    if (recvQ.size() == 3) begin
      chk("bp_first", 32'(recvQ[0]), 32'hA1);
      chk("bp_second", 32'(recvQ[1]), 32'hA2);
      chk("bp_third", 32'(recvQ[2]), 32'hA3);
    end

    // Flush while empty with an input offered: the input is discarded.
    srcQ = '{8'h66};
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("flush_empty_src", 32'(srcQ.size()), 32'd0);

    // Flush with the stage fully back-pressured and 0x55 offered.
    srcQ = '{8'hB1, 8'hB2, 8'h55};
    recvQ.delete();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_occupancy", 32'(occupancy), 32'd0);
    chk("flush_out_data", 32'(out_data), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    srcQ.delete();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    chk("flush_no_55", 32'(recvQ.size()), 32'd0);

    // Flush together with an output transfer: the head still leaves.
    srcQ = '{8'hD1};
    recvQ.delete();
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("flush_out_xfer", 32'(recvQ.size()), 32'd1);

    // Stall counter saturation.
    srcQ = '{8'hC1};
    for (int i = 0; i < 21; i++) cycle(1'b0, 1'b0, 1'b1);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);

    // Asynchronous reset while holding a payload.
    srcQ = '{8'hE1};
    cycle(1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    mq.delete();
    srcQ.delete();
    mStall = 0;
    @(negedge clk);
    reset = 1'b1;
    srcQ = '{8'hF1, 8'hF2};
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and optional skid buffering. It generalises the fixed-width, always-enabled stage latches between CPU pipeline stages (e.g. E->M) into one reusable block of arbitrary payload width. Back-pressure replaces the hard-wired enable, and a stall-cycle counter is added for performance analysis.

## Interface
- WIDTH, 224, payload width in bits (control + data + exception bits concatenated by the instantiator)
- CNT_W, 16, width of the stall-cycle counter
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous flush; discards all held entries
- in_valid  input  1  upstream has a payload
- in_ready  output  1  block can accept a payload this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a valid payload
- out_ready  input  1  downstream consumes out_data this cycle
- out_data  output  WIDTH  head payload
- occupancy  output  2  entries held (0..2)
- stall_cnt  output  CNT_W  saturating count of downstream stall cycles

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- Storage: main register (drives out_data), plus skid register when PIPE_SKID_EN is defined.
- State machine with PIPE_SKID_EN defined:
  - EMPTY (occupancy 0): on in_valid, go to FULL and set main <= in_data.
  - FULL (occupancy 1):
    - in_valid & out_ready: stay in FULL, main <= in_data.
    - in_valid & ~out_ready: go to SKID, skid <= in_data.
    - ~in_valid & out_ready: go to EMPTY.
  - SKID (occupancy 2): on out_ready, go to FULL, main <= skid. No input is accepted in SKID.
  - in_ready = (state != SKID). It is a registered signal with no combinational path from out_ready.
- Without PIPE_SKID_EN: states are EMPTY and FULL only.
  - in_ready = ~out_valid | out_ready, which is combinational from out_ready.
  - FULL with in_valid & out_ready: main is replaced and the state stays FULL.
  - occupancy never exceeds 1.
- out_valid = (state != EMPTY). The payload is never modified while held. Ordering is strictly FIFO.
- Flush has the highest priority:
  - Next state is EMPTY; main and skid are cleared to 0.
  - A simultaneous input transfer is discarded, even if in_ready was 1.
  - A simultaneous output transfer still completes for the downstream side.
- stall_cnt increments on each cycle with out_valid & ~out_ready.
  - It saturates at 2^CNT_W-1.
  - It is not cleared by flush.

## Timing
- Reset (reset=0, asynchronous assert, synchronous release edge):
  - state EMPTY, out_valid 0, out_data 0, occupancy 0, stall_cnt 0.
  - in_ready: 1 with PIPE_SKID_EN; 1 without it (out_valid=0).
- Latency: a payload accepted at edge t appears on out_data/out_valid after edge t. This is 1 cycle, the same as the legacy latch.
- Throughput: 1 payload/cycle when out_ready is held high, in both configurations.
- With PIPE_SKID_EN, in_ready falls 1 cycle after the stall begins.
  - The payload captured in that cycle goes to the skid register; none is lost.
- Reset asserted mid-operation: all entries are dropped immediately (asynchronously), and the counter is cleared.
- Flush in SKID: both entries are dropped; in_ready = 1 on the next cycle.

## Configuration
- PIPE_SKID_EN defined: 2-entry skid buffer, registered in_ready, occupancy up to 2. This breaks the ready timing path across stages.
- PIPE_SKID_EN undefined: single register, combinational in_ready, no skid storage synthesised. Occupancy bit 1 is tied to 0.

## Test plan
- Reset: hold reset=0 with random inputs -> out_valid=0, out_data=0, stall_cnt=0, occupancy=0. Release -> in_ready=1.
- Streaming: WIDTH=8, out_ready=1, in_data 0x01..0x10 on consecutive cycles -> out_data 0x01..0x10 one cycle later, no bubbles, stall_cnt=0.
- Back-pressure (PIPE_SKID_EN): stream 0xA1, 0xA2, 0xA3 and drop out_ready after 0xA1 is shown for 3 cycles.
  - Required: occupancy=2, in_ready=0, stall_cnt=3.
  - Raise out_ready -> 0xA1, 0xA2, 0xA3 delivered in order, none duplicated.
- Flush: in SKID state, pulse flush with in_valid=1, in_data=0x55 -> next cycle out_valid=0, occupancy=0, and 0x55 never appears.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- No-skid build: repeat the back-pressure case -> in_ready=0 in the same cycle out_ready drops, occupancy never exceeds 1, and no payload is lost.
